// File: rtl/usb_fs_in_ep.sv
// Single-packet IN endpoint buffer: collects one packet, replays it per IN token until ACKed, handles DATA0/1, NAK and STALL.
// Latency: put readable on tx_data the next cycle; commit reaches READY one cycle after the commit event; acked pulses one cycle after ACK.
// Backpressure: in_ep_data_free drops once the packet is committed or full, and returns after the host ACKs it; puts while low are dropped.
module usb_fs_in_ep #(
  parameter int MAX_PKT = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_ep_req,
  output logic       in_ep_grant,
  output logic       in_ep_data_free,
  input  logic       in_ep_data_put,
  input  logic [7:0] in_ep_data,
  input  logic       in_ep_data_done,
  input  logic       in_ep_stall,
  output logic       in_ep_acked,
  input  logic       setup_token_received,
  input  logic       in_xfr_start,
  input  logic       in_xfr_ack,
  output logic       tx_pkt_nak,
  output logic       tx_pkt_stall,
  output logic       tx_data_toggle,
  output logic       tx_data_avail,
  input  logic       tx_data_get,
  output logic [7:0] tx_data
);

  localparam int AW = $clog2(MAX_PKT + 1);
  localparam int IW = $clog2(MAX_PKT);
  localparam logic [AW-1:0] PKT_LEN = AW'(MAX_PKT);
  localparam logic [AW-1:0] PKT_LAST = AW'(MAX_PKT - 1);

  typedef enum logic [1:0] {FILL, READY, SENDING} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          stall;
  logic          toggle;
  logic          done_pending;
  logic          acked;
  logic [7:0]    mem [MAX_PKT];
  logic          put_ok;
  logic          put_wr;

  assign in_ep_grant     = in_ep_req;
  assign in_ep_data_free = (state == FILL) && (wr_ptr < PKT_LEN) && !stall;
  assign put_ok          = in_ep_data_put && in_ep_data_free;
  // A put landing together with a setup or stall belongs to the flushed packet.
  assign put_wr          = put_ok && !setup_token_received && !in_ep_stall;

  assign tx_pkt_nak      = !stall && (state == FILL);
  assign tx_pkt_stall    = stall;
  assign tx_data_toggle  = toggle;
  assign tx_data_avail   = (state == SENDING) && (rd_ptr < wr_ptr);
  assign tx_data         = (rd_ptr < PKT_LEN) ? mem[rd_ptr[IW-1:0]] : 8'h00;
  assign in_ep_acked     = acked;

  // Packet storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (put_wr) mem[wr_ptr[IW-1:0]] <= in_ep_data;
  end

  // Endpoint state machine: setup > stall > ack > start > done/put.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FILL;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      stall        <= 1'b0;
      toggle       <= 1'b0;
      done_pending <= 1'b0;
      acked        <= 1'b0;
    end else begin
      acked <= 1'b0;
      if (setup_token_received) begin
        stall        <= 1'b0;
        done_pending <= 1'b0;
        toggle       <= 1'b1;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        state        <= FILL;
      end else if (in_ep_stall) begin
        stall        <= 1'b1;
        done_pending <= 1'b0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        state        <= FILL;
      end else begin
        case (state)
          FILL: begin
            if (put_ok) wr_ptr <= wr_ptr + 1'b1;
            // Explicit done, a deferred done (trailing ZLP) or the last free slot commits.
            if (!stall && (in_ep_data_done || done_pending ||
                           (put_ok && wr_ptr == PKT_LAST))) begin
              state        <= READY;
              done_pending <= 1'b0;
            end
          end
          READY: begin
            if (in_xfr_start) begin
              state  <= SENDING;
              rd_ptr <= '0;
            end
            if (in_ep_data_done) done_pending <= 1'b1;
          end
          SENDING: begin
            if (in_xfr_ack) begin
              toggle <= ~toggle;
              wr_ptr <= '0;
              acked  <= 1'b1;
              state  <= FILL;
            end else if (in_xfr_start) begin
              // Host retried: replay the same bytes under the same PID.
              rd_ptr <= '0;
            end else if (tx_data_avail && tx_data_get) begin
              rd_ptr <= rd_ptr + 1'b1;
            end
            if (in_ep_data_done) done_pending <= 1'b1;
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule
